cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu.sv | 153 +++++++++++++++
 tb/tb_cpu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Multi-cycle 32-bit CPU with 17-bit word addressing, read-only memory port.
// Define CPU_TRACE_EN to print one simulation line per instruction fetch.
module cpu (
    input  logic        reset,
    input  logic        clock,
    input  logic [0:31] data_in,
    output logic [0:16] address
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned NREG   = 16;
    localparam int unsigned IMM_W  = 20;

    localparam logic [6:0] OP_AI   = 7'h20;
    localparam logic [6:0] OP_LI   = 7'h22;
    localparam logic [6:0] OP_WAIT = 7'h2E;
    localparam logic [6:0] OP_AW   = 7'h30;
    localparam logic [6:0] OP_LW   = 7'h32;
    localparam logic [6:0] OP_BCR  = 7'h68;
    localparam logic [6:0] OP_BCS  = 7'h69;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        INDIRECT = 2'd1,
        EXECUTE  = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [WORD_W-1:0]   ir;
    logic [3:0]          cc;     // {CC1, CC2, CC3, CC4}
    logic [WORD_W-1:0]   regs [NREG];

    // Memory word renumbered so that spec bit k is din[31-k].
    logic [WORD_W-1:0]   din;
    logic [6:0]          f_op;
    logic [2:0]          f_x;
    logic [ADDR_W-1:0]   f_idx;
    logic [ADDR_W-1:0]   f_ea;
    logic                f_memref;
    logic [6:0]          e_op;
    logic [3:0]          e_r;
    logic [WORD_W-1:0]   imm;
    logic [WORD_W-1:0]   opnd;
    logic [WORD_W-1:0]   acc;
    logic [WORD_W:0]     sum;
    logic [WORD_W-1:0]   res;
    logic                carry;
    logic                ovf;
    logic                pos;
    logic                neg;
    logic                cc_hit;
    logic                ir_unused;

    assign din = data_in;

    // Fetch-time decode straight from the memory word being latched into IR.
    assign f_op     = din[30:24];
    assign f_x      = din[19:17];
    assign f_idx    = (f_x != 3'd0) ? regs[f_x][ADDR_W-1:0] : '0;
    assign f_ea     = din[ADDR_W-1:0] + f_idx;
    assign f_memref = (f_op == OP_LW) || (f_op == OP_AW) ||
                      (f_op == OP_BCR) || (f_op == OP_BCS);

    // Execute-time datapath; the address register holds EA during EXECUTE.
    assign e_op  = ir[30:24];
    assign e_r   = ir[23:20];
    assign imm   = {{(WORD_W - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign opnd  = ((e_op == OP_LI) || (e_op == OP_AI)) ? imm : din;
    assign acc   = regs[e_r];
    assign sum   = {1'b0, acc} + {1'b0, opnd};
    assign res   = ((e_op == OP_LI) || (e_op == OP_LW)) ? opnd : sum[WORD_W-1:0];
    assign carry = sum[WORD_W];
    assign ovf   = (acc[WORD_W-1] == opnd[WORD_W-1]) && (sum[WORD_W-1] != acc[WORD_W-1]);
    assign pos   = !res[WORD_W-1] && (res != '0);
    assign neg   = res[WORD_W-1];
    assign cc_hit = (e_r & cc) != 4'd0;

    // The indirect flag is consumed at fetch time, before IR is loaded.
    assign ir_unused = ir[WORD_W-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            cc      <= '0;
            address <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    ir      <= din;
                    pc      <= pc + ADDR_W'(1);
                    address <= f_ea;
                    state   <= (din[WORD_W-1] && f_memref) ? INDIRECT : EXECUTE;
                end
                INDIRECT: begin
                    address <= din[ADDR_W-1:0];
                    state   <= EXECUTE;
                end
                EXECUTE: begin
                    state   <= FETCH;
                    address <= pc;
                    case (e_op)
                        OP_LI, OP_LW: begin
                            regs[e_r] <= res;
                            cc[1:0]   <= {pos, neg};
                        end
                        OP_AI, OP_AW: begin
                            regs[e_r] <= res;
                            cc        <= {carry, ovf, pos, neg};
                        end
                        OP_BCR: begin
                            if (!cc_hit) begin
                                pc      <= address;
                                address <= address;
                            end
                        end
                        OP_BCS: begin
                            if (cc_hit) begin
                                pc      <= address;
                                address <= address;
                            end
                        end
                        default: begin
                            // WAIT and any unimplemented opcode stop the machine.
                            state <= HALT;
                        end
                    endcase
                end
                default: begin
                    address <= pc;
                end
            endcase
        end
    end

`ifdef CPU_TRACE_EN
    always_ff @(posedge clock) begin
        if (!reset && state == FETCH) begin
            $display("cpu fetch pc=%05h ir=%08h", pc, din);
        end
    end
`else
    // Tracing compiled out; cycle behaviour is identical either way.
`endif

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: instruction-level reference model plus cycle-by-cycle address checks.
module tb_cpu;

    logic        reset;
    logic        clock;
    logic [0:31] data_in;
    logic [0:16] address;

    logic [31:0] mem [256];
    logic [16:0] addr_v;

    int checks;
    int passes;

    logic [31:0] m_regs [16];
    logic [16:0] m_pc;
    logic [3:0]  m_cc;
    bit          m_halted;
    logic [16:0] trace [$];

    cpu dut (
        .reset   (reset),
        .clock   (clock),
        .data_in (data_in),
        .address (address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory aliases every 256 words, so 0x1FFFF reads mem[0xFF].
    assign addr_v  = address;
    assign data_in = mem[addr_v[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    function automatic void set_nz(input logic [31:0] v);
        m_cc[1] = ($signed(v) > 0);
        m_cc[0] = v[31];
    endfunction

    function automatic void do_add(input logic [3:0] r, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] a;
        a = m_regs[r];
        s = {1'b0, a} + {1'b0, b};
        m_regs[r] = s[31:0];
        m_cc[3] = s[32];
        m_cc[2] = (a[31] == b[31]) && (s[31] != a[31]);
        set_nz(s[31:0]);
    endfunction

    // Instruction-level interpreter that emits the expected address of every cycle.
    task automatic model_run(input int n);
        logic [31:0] w, imm, tmp, rx;
        logic [6:0]  op;
        logic [3:0]  r;
        logic [2:0]  x;
        logic [16:0] ea;
        m_pc = '0;
        m_cc = '0;
        m_halted = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        trace.delete();
        while (trace.size() < n) begin
            if (m_halted) begin
                trace.push_back(m_pc);
            end else begin
                w = mem[m_pc[7:0]];
                trace.push_back(m_pc);
                m_pc = m_pc + 17'd1;
                op = w[30:24];
                r  = w[23:20];
                x  = w[19:17];
                rx = m_regs[x];
                ea = w[16:0] + ((x != 3'd0) ? rx[16:0] : 17'd0);
                if (w[31] && (op == 7'h32 || op == 7'h30 || op == 7'h68 || op == 7'h69)) begin
                    trace.push_back(ea);
                    tmp = mem[ea[7:0]];
                    ea  = tmp[16:0];
                end
                trace.push_back(ea);
                imm = {{12{w[19]}}, w[19:0]};
                case (op)
                    7'h22: begin m_regs[r] = imm; set_nz(imm); end
                    7'h20: do_add(r, imm);
                    7'h32: begin m_regs[r] = mem[ea[7:0]]; set_nz(m_regs[r]); end
                    7'h30: do_add(r, mem[ea[7:0]]);
                    7'h68: if ((r & m_cc) == 4'd0) m_pc = ea;
                    7'h69: if ((r & m_cc) != 4'd0) m_pc = ea;
                    default: m_halted = 1'b1;
                endcase
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    // Reset for two cycles, check the reset state, release at a falling edge.
    task automatic start_prog(input string tag);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check({tag, " rst addr"}, 32'(address), 32'h0);
        check({tag, " rst pc"}, 32'(dut.pc), 32'h0);
        check({tag, " rst cc"}, 32'(dut.cc), 32'h0);
        check({tag, " rst ir"}, dut.ir, 32'h0);
        for (int i = 0; i < 16; i++) check($sformatf("%s rst R%0d", tag, i), dut.regs[i], 32'h0);
        reset = 1'b0;
    endtask

    task automatic compare_run(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s addr cyc%0d", tag, k), 32'(address), 32'(trace[k]));
            @(negedge clock);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 16; i++) check($sformatf("%s R%0d", tag, i), dut.regs[i], m_regs[i]);
        check({tag, " cc"}, 32'(dut.cc), 32'(m_cc));
    endtask

    initial begin
        reset  = 1'b1;
        checks = 0;
        passes = 0;

        // LI R1,5 ; WAIT
        clear_mem();
        mem[0] = 32'h22100005;
        mem[1] = 32'h2E000000;
        model_run(8);
        start_prog("p1");
        compare_run("p1", 8);
        check_state("p1");
        check("p1 R1 lit", dut.regs[1], 32'h00000005);
        check("p1 cc lit", 32'(dut.cc), 32'h2);
        check("p1 halt addr", 32'(address), 32'h00002);

        // LI R2,-1 ; AI R2,1 ; WAIT
        clear_mem();
        mem[0] = 32'h222FFFFF;
        mem[1] = 32'h20200001;
        mem[2] = 32'h2E000000;
        model_run(10);
        start_prog("p2");
        compare_run("p2", 10);
        check_state("p2");
        check("p2 R2 lit", dut.regs[2], 32'h0);
        check("p2 cc lit", 32'(dut.cc), 32'h8);

        // LW R3,0x40 ; AW R3,0x40 ; WAIT
        clear_mem();
        mem[0]    = 32'h32300040;
        mem[1]    = 32'h30300040;
        mem[2]    = 32'h2E000000;
        mem[8'h40] = 32'h7FFFFFFF;
        model_run(10);
        start_prog("p3");
        compare_run("p3", 10);
        check_state("p3");
        check("p3 R3 lit", dut.regs[3], 32'hFFFFFFFE);
        check("p3 cc lit", 32'(dut.cc), 32'h5);

        // LI R4,0x10 ; LW R5,0x30(X=4) ; LW R6,@0x50 ; WAIT
        clear_mem();
        mem[0]     = 32'h22400010;
        mem[1]     = 32'h32580030;
        mem[2]     = 32'hB2600050;
        mem[3]     = 32'h2E000000;
        mem[8'h40] = 32'h7FFFFFFF;
        mem[8'h50] = 32'h00000040;
        model_run(12);
        check("p4 model indexed ea", 32'(trace[3]), 32'h40);
        check("p4 model wait fetch", 32'(trace[7]), 32'h3);
        start_prog("p4");
        compare_run("p4", 12);
        check_state("p4");
        check("p4 R5 lit", dut.regs[5], 32'h7FFFFFFF);
        check("p4 R6 lit", dut.regs[6], 32'h7FFFFFFF);

        // LI R7,-1 ; BCS 1,0x20 ; @0x20: BCR 1,0x30 ; WAIT
        clear_mem();
        mem[0]     = 32'h227FFFFF;
        mem[1]     = 32'h69100020;
        mem[8'h20] = 32'h68100030;
        mem[8'h21] = 32'h2E000000;
        model_run(12);
        check("p5 model bcs target", 32'(trace[4]), 32'h20);
        check("p5 model bcr fall", 32'(trace[6]), 32'h21);
        start_prog("p5");
        compare_run("p5", 12);
        check_state("p5");
        check("p5 cc lit", 32'(dut.cc), 32'h1);

        // Reset pulsed during EXECUTE of LW R3
        clear_mem();
        mem[0]     = 32'h22300007;
        mem[1]     = 32'h32300040;
        mem[2]     = 32'h2E000000;
        mem[8'h40] = 32'h7FFFFFFF;
        model_run(10);
        start_prog("p6");
        compare_run("p6", 3);
        check("p6 lw exec addr", 32'(address), 32'h40);
        reset = 1'b1;
        @(negedge clock);
        check("p6 R3 after abort", dut.regs[3], 32'h0);
        check("p6 addr after abort", 32'(address), 32'h0);
        check("p6 pc after abort", 32'(dut.pc), 32'h0);
        reset = 1'b0;
        compare_run("p6r", 10);
        check_state("p6r");

        // PC wrap: branch to 0x1FFFF, next fetch comes from 0
        clear_mem();
        mem[0]     = 32'h228FFFFF;
        mem[1]     = 32'h6911FFFF;
        mem[8'hFF] = 32'h22900003;
        model_run(14);
        check("p7 model wrap", 32'(trace[6]), 32'h0);
        start_prog("p7");
        compare_run("p7", 14);
        check("p7 R9 lit", dut.regs[9], 32'h3);

        // Unimplemented opcode halts with PC held
        clear_mem();
        mem[0] = 32'h01000000;
        model_run(6);
        start_prog("p8");
        compare_run("p8", 6);
        check_state("p8");
        check("p8 halt addr", 32'(address), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
